conv_window_gen: RTL

- Next-generation 3x3 sliding-window generator for the conv datapath.
- Consumes a zero-padded feature map streamed row-major, pixel by pixel. Each pixel is D = in_channels/8 consecutive 64-bit vectors (channel groups).
- Emits one 3x3 window of vectors per qualifying input beat, with stride 1 or 2.
- Adds valid/ready backpressure on both sides, per-frame configuration latch, explicit frame-end marking and configuration error checking.

---
 rtl/conv_window_gen.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a zero-padded, row-major stream of channel-group vectors.
// Optional perf counters are built when CONV_WINDOW_PERF_EN is defined.
module conv_window_gen #(
    parameter int unsigned VEC_W   = 64,
    parameter int unsigned MAX_VPR = 8192,
    parameter int unsigned MAX_D   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        cfg_in_channels,
    input  logic [15:0]        cfg_img_width,
    input  logic [15:0]        cfg_img_height,
    input  logic               cfg_stride2,
    input  logic [VEC_W-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [9*VEC_W-1:0] win_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [31:0]        perf_windows,
    output logic [31:0]        perf_stalls
);
    localparam int unsigned PW = (MAX_VPR > 1) ? $clog2(MAX_VPR) : 1;
    localparam int unsigned GW = (MAX_D > 1) ? $clog2(MAX_D) : 1;
    localparam logic [31:0] MAX_CH    = 32'(8 * MAX_D);
    localparam logic [31:0] MAX_VPR_L = 32'(MAX_VPR);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t          state;
    logic [15:0]     y, x;
    logic [GW-1:0]   g;
    logic [PW-1:0]   lb_ptr;
    logic [GW-1:0]   d_m1;
    logic [PW-1:0]   vpr_m1;
    logic [15:0]     w_m1, h_m1, x_last, y_last;
    logic            stride2;

    // Line buffers: lb_mid holds row y-1, lb_old holds row y-2 at the current row offset.
    logic [VEC_W-1:0] lb_mid [MAX_VPR];
    logic [VEC_W-1:0] lb_old [MAX_VPR];
    // Column delay lines indexed by group: col1 is pixel x-1, col2 is pixel x-2.
    logic [VEC_W-1:0] col1 [3][MAX_D];
    logic [VEC_W-1:0] col2 [3][MAX_D];
    logic [VEC_W-1:0] row_v [3];

    logic [9*VEC_W-1:0] win_next;
    logic               accept, qual, is_last_win, end_beat, start_ok, out_hs;

    logic [15:0] cfg_d, w_m3, h_m3, cfg_x_last, cfg_y_last;
    logic [31:0] cfg_vpr;
    logic        cfg_ok;

    assign cfg_d   = {3'b000, cfg_in_channels[15:3]};
    assign cfg_vpr = {16'b0, cfg_img_width} * {16'b0, cfg_d};
    assign cfg_ok  = (cfg_in_channels != 16'd0) && (cfg_in_channels[2:0] == 3'b000) &&
                     ({16'b0, cfg_in_channels} <= MAX_CH) &&
                     (cfg_img_width >= 16'd3) && (cfg_img_height >= 16'd3) &&
                     (cfg_vpr <= MAX_VPR_L);

    assign w_m3       = cfg_img_width - 16'd3;
    assign h_m3       = cfg_img_height - 16'd3;
    assign cfg_x_last = cfg_stride2 ? 16'd2 + {w_m3[15:1], 1'b0} : cfg_img_width - 16'd1;
    assign cfg_y_last = cfg_stride2 ? 16'd2 + {h_m3[15:1], 1'b0} : cfg_img_height - 16'd1;

    assign in_ready = (state == StRun) && (!out_valid || out_ready);
    assign busy     = (state != StIdle);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign start_ok = (state == StIdle) && start && cfg_ok;

    // With stride 2, (y-2) even is the same as y even.
    assign qual        = (y >= 16'd2) && (x >= 16'd2) && (!stride2 || (!y[0] && !x[0]));
    assign is_last_win = (y == y_last) && (x == x_last) && (g == d_m1);
    assign end_beat    = (y == h_m1) && (x == w_m1) && (g == d_m1);

    always_comb begin
        row_v[0] = lb_old[lb_ptr];
        row_v[1] = lb_mid[lb_ptr];
        row_v[2] = in_data;
    end

    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            win_next[(r*3+2)*VEC_W +: VEC_W] = row_v[r];
            win_next[(r*3+1)*VEC_W +: VEC_W] = col1[r][g];
            win_next[(r*3)*VEC_W +: VEC_W]   = col2[r][g];
        end
    end

    // Storage is never reset; stale contents are masked by the emit condition.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_mid[lb_ptr] <= in_data;
            lb_old[lb_ptr] <= row_v[1];
            for (int r = 0; r < 3; r++) begin
                col1[r][g] <= row_v[r];
                col2[r][g] <= col1[r][g];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            y         <= '0;
            x         <= '0;
            g         <= '0;
            lb_ptr    <= '0;
            d_m1      <= '0;
            vpr_m1    <= '0;
            w_m1      <= '0;
            h_m1      <= '0;
            x_last    <= '0;
            y_last    <= '0;
            stride2   <= 1'b0;
            win_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (accept && qual) begin
                out_valid <= 1'b1;
                win_data  <= win_next;
                out_last  <= is_last_win;
            end
            unique case (state)
                StIdle: begin
                    if (start_ok) begin
                        d_m1    <= GW'(cfg_d - 16'd1);
                        vpr_m1  <= PW'(cfg_vpr - 32'd1);
                        w_m1    <= cfg_img_width - 16'd1;
                        h_m1    <= cfg_img_height - 16'd1;
                        x_last  <= cfg_x_last;
                        y_last  <= cfg_y_last;
                        stride2 <= cfg_stride2;
                        y       <= '0;
                        x       <= '0;
                        g       <= '0;
                        lb_ptr  <= '0;
                        state   <= StRun;
                    end else if (start) begin
                        cfg_err <= 1'b1;
                    end
                end
                StRun: begin
                    if (accept) begin
                        lb_ptr <= (lb_ptr == vpr_m1) ? '0 : lb_ptr + 1'b1;
                        if (g == d_m1) begin
                            g <= '0;
                            if (x == w_m1) begin
                                x <= '0;
                                y <= (y == h_m1) ? 16'd0 : y + 16'd1;
                            end else begin
                                x <= x + 16'd1;
                            end
                        end else begin
                            g <= g + 1'b1;
                        end
                        if (end_beat) state <= StDrain;
                    end
                end
                StDrain: begin
                    if (!out_valid || out_ready) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef CONV_WINDOW_PERF_EN
    logic [31:0] pw_cnt, ps_cnt;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            pw_cnt <= '0;
            ps_cnt <= '0;
        end else begin
            if (out_hs && (pw_cnt != 32'hFFFF_FFFF)) pw_cnt <= pw_cnt + 32'd1;
            if (out_valid && !out_ready && (ps_cnt != 32'hFFFF_FFFF)) ps_cnt <= ps_cnt + 32'd1;
        end
    end

    assign perf_windows = pw_cnt;
    assign perf_stalls  = ps_cnt;
`else
    assign perf_windows = 32'd0;
    assign perf_stalls  = 32'd0;
`endif

endmodule
